// File: rtl/sine_seq_ctrl_if.sv
// Request/response bundle for the sequenced sine evaluator: start/angle in,
// busy/done/result/range flag out.
interface sine_seq_ctrl_if #(
  parameter int N = 24
);
  logic         i_start;
  logic [N-1:0] i_angle;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_sin;
  logic         o_range_err;

  modport master (
    output i_start, i_angle,
    input  o_busy, o_done, o_sin, o_range_err
  );

  modport slave (
    input  i_start, i_angle,
    output o_busy, o_done, o_sin, o_range_err
  );
endinterface

// File: rtl/sine_seq_ctrl.sv
// Sequenced sine: one shared sign-magnitude Q12.12 multiplier and adder stepped
// through a 7th-order odd polynomial. Define SINE_SEQ_QUADRANT_EN to add the quadrant fold.
module qmult_SN #(
  parameter int N = 24,
  parameter int Q = 12
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);
  localparam int W = 2 * (N - 1);

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [N-2:0] mag;

  assign a_ext = W'(a_i[N-2:0]);
  assign b_ext = W'(b_i[N-2:0]);
  // Keep bits [N-2+Q:Q] of the full product; anything above is dropped, not saturated.
  assign mag   = (N-1)'((a_ext * b_ext) >> Q);
  assign p_o   = {a_i[N-1] ^ b_i[N-1], mag};
endmodule

module qadd_SN #(
  parameter int N = 24
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] s_o
);
  logic [N-2:0] a_mag;
  logic [N-2:0] b_mag;
  logic [N-2:0] mag;
  logic         sgn;

  assign a_mag = a_i[N-2:0];
  assign b_mag = b_i[N-2:0];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    mag = '0;
    sgn = 1'b0;
    if (a_i[N-1] == b_i[N-1]) begin
      mag = a_mag + b_mag;
      sgn = a_i[N-1];
    end else if (a_mag >= b_mag) begin
      mag = a_mag - b_mag;
      sgn = a_i[N-1];
    end else begin
      mag = b_mag - a_mag;
      sgn = b_i[N-1];
    end
  end

  assign s_o = {sgn & (mag != '0), mag};
endmodule

module sine_seq_ctrl #(
  parameter int N = 24,
  parameter int Q = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sine_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [3:0] {
    S_Y, S_FOLD, S_Y2, S_Y3, S_ACC1, S_ACC3, S_Y5, S_ACC5, S_Y7, S_ACC7
  } step_t;

  localparam logic [N-1:0] K_C  = 24'h000A2F;
  localparam logic [N-1:0] C1_C = 24'h001921;
  localparam logic [N-1:0] C3_C = 24'h800A56;
  localparam logic [N-1:0] C5_C = 24'h000146;
  localparam logic [N-1:0] C7_C = 24'h800013;
  localparam logic [N-2:0] ONE  = (N-1)'(1) << Q;

  state_t       state_q, state_d;
  step_t        step_q, step_d;
  logic [N-1:0] ang_q, ang_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] y2_q, y2_d;
  logic [N-1:0] y3_q, y3_d;
  logic [N-1:0] y5_q, y5_d;
  logic [N-1:0] y7_q, y7_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] sin_q, sin_d;
  logic         rerr_q, rerr_d;
  logic         range_err_q, range_err_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [N-1:0] mul_a, mul_b, mul_p, add_s;

  qmult_SN #(.N(N), .Q(Q)) u_mult (.a_i(mul_a), .b_i(mul_b), .p_o(mul_p));
  qadd_SN  #(.N(N))        u_add  (.a_i(acc_q), .b_i(mul_p), .s_o(add_s));

`ifdef SINE_SEQ_QUADRANT_EN
  logic [1:0]   quad;
  logic [N-2:0] frac;
  logic [N-2:0] fold_mag;
  logic         fold_neg;
  logic [N-1:0] fold_y;

  assign quad = y_q[Q+1:Q];
  assign frac = {{(N-1-Q){1'b0}}, y_q[Q-1:0]};

  // Quadrants 1 and 3 mirror about 1.0; quadrants 2 and 3 flip the sign.
  always_comb begin
    fold_mag = frac;
    fold_neg = 1'b0;
    case (quad)
      2'd1: fold_mag = ONE - frac;
      2'd2: fold_neg = 1'b1;
      2'd3: begin
        fold_mag = ONE - frac;
        fold_neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign fold_y = {(fold_neg ^ y_q[N-1]) & (fold_mag != '0), fold_mag};
`endif

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (step_q)
      S_Y:    begin mul_a = ang_q; mul_b = K_C;  end
      S_Y2:   begin mul_a = y_q;   mul_b = y_q;  end
      S_Y3:   begin mul_a = y_q;   mul_b = y2_q; end
      S_ACC1: begin mul_a = y_q;   mul_b = C1_C; end
      S_ACC3: begin mul_a = y3_q;  mul_b = C3_C; end
      S_Y5:   begin mul_a = y3_q;  mul_b = y2_q; end
      S_ACC5: begin mul_a = y5_q;  mul_b = C5_C; end
      S_Y7:   begin mul_a = y5_q;  mul_b = y2_q; end
      S_ACC7: begin mul_a = y7_q;  mul_b = C7_C; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ang_d       = ang_q;
    y_d         = y_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    y5_d        = y5_q;
    y7_d        = y7_q;
    acc_d       = acc_q;
    sin_d       = sin_q;
    rerr_d      = rerr_q;
    range_err_d = range_err_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = RUN;
          ang_d   = bus.i_angle;
          step_d  = S_Y;
          acc_d   = '0;
        end
      end
      RUN: begin
        case (step_q)
          S_Y: begin
            y_d = mul_p;
`ifdef SINE_SEQ_QUADRANT_EN
            rerr_d = 1'b0;
            step_d = S_FOLD;
`else
            rerr_d = (mul_p[N-2:0] > ONE);
            step_d = S_Y2;
`endif
          end
`ifdef SINE_SEQ_QUADRANT_EN
          S_FOLD: begin
            y_d    = fold_y;
            step_d = S_Y2;
          end
`endif
          S_Y2:   begin y2_d  = mul_p; step_d = S_Y3;   end
          S_Y3:   begin y3_d  = mul_p; step_d = S_ACC1; end
          S_ACC1: begin acc_d = mul_p; step_d = S_ACC3; end
          S_ACC3: begin acc_d = add_s; step_d = S_Y5;   end
          S_Y5:   begin y5_d  = mul_p; step_d = S_ACC5; end
          S_ACC5: begin acc_d = add_s; step_d = S_Y7;   end
          S_Y7:   begin y7_d  = mul_p; step_d = S_ACC7; end
          S_ACC7: begin
            acc_d   = add_s;
            state_d = DONE;
          end
          default: state_d = IDLE;
        endcase
      end
      DONE: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        sin_d       = (acc_q[N-2:0] == '0) ? '0 : acc_q;
        range_err_d = rerr_q;
      end
      default: state_d = IDLE;
    endcase

    // Busy covers the done pulse so it drops on the same edge as o_done.
    busy_d = (state_d != IDLE) || done_d;
  end

  // NOTE: sequential state uses non-blocking assignments; every register, data included,
  // is reset so an aborted run leaves nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      step_q      <= S_Y;
      ang_q       <= '0;
      y_q         <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      y5_q        <= '0;
      y7_q        <= '0;
      acc_q       <= '0;
      sin_q       <= '0;
      rerr_q      <= 1'b0;
      range_err_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ang_q       <= ang_d;
      y_q         <= y_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      y5_q        <= y5_d;
      y7_q        <= y7_d;
      acc_q       <= acc_d;
      sin_q       <= sin_d;
      rerr_q      <= rerr_d;
      range_err_q <= range_err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_sin       = sin_q;
  assign bus.o_range_err = range_err_q;
endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Scoreboard bench for sine_seq_ctrl: stimulus pushes expected results, a
// monitor pops and compares on every o_done pulse.
module tb_sine_seq_ctrl;
  localparam int N = 24;
`ifdef SINE_SEQ_QUADRANT_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 10;
`endif
  localparam int GAP = LAT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_seq_ctrl_if #(.N(N)) bus ();
  sine_seq_ctrl #(.N(N), .Q(12)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [23:0] exp_sin;
    int          tol;
    bit          chk_sin;
    bit          exp_rerr;
    int          accept_cyc;
    int          exp_lat;
    int          exp_gap;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    done_total = 0;
  int    last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int sm2int(input logic [23:0] v);
    return v[23] ? -int'(v[22:0]) : int'(v[22:0]);
  endfunction

  // Monitor: compare every completed result against the head of the scoreboard.
  initial begin
    forever begin
      exp_t  e;
      string nm;
      int    d;
      @(negedge clk);
      if (rst_n && bus.o_done) begin
        done_total++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1'b0, $sformatf("o_sin=%06h with nothing pending", bus.o_sin));
        end else begin
          e  = sb.pop_front();
          nm = sb_name.pop_front();
          if (e.chk_sin) begin
            if (e.tol == 0) begin
              check({nm, "_sin"}, bus.o_sin === e.exp_sin,
                    $sformatf("got %06h want %06h", bus.o_sin, e.exp_sin));
            end else begin
              d = sm2int(bus.o_sin) - sm2int(e.exp_sin);
              check({nm, "_sin"}, (d <= e.tol) && (d >= -e.tol),
                    $sformatf("got %06h want %06h +/-%0d", bus.o_sin, e.exp_sin, e.tol));
            end
          end
          check({nm, "_rerr"}, bus.o_range_err === e.exp_rerr,
                $sformatf("got %b want %b", bus.o_range_err, e.exp_rerr));
          check({nm, "_busy_at_done"}, bus.o_busy === 1'b1,
                $sformatf("got %b want 1", bus.o_busy));
          if (e.exp_lat != 0)
            check({nm, "_latency"}, (cyc - e.accept_cyc) == e.exp_lat,
                  $sformatf("got %0d want %0d", cyc - e.accept_cyc, e.exp_lat));
          if (e.exp_gap != 0)
            check({nm, "_gap"}, (cyc - last_done_cyc) == e.exp_gap,
                  $sformatf("got %0d want %0d", cyc - last_done_cyc, e.exp_gap));
        end
        last_done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input string nm, input logic [23:0] s, input int tol, input bit chk,
                          input bit rerr, input int acc, input int lat, input int gap);
    exp_t e;
    e.exp_sin    = s;
    e.tol        = tol;
    e.chk_sin    = chk;
    e.exp_rerr   = rerr;
    e.accept_cyc = acc;
    e.exp_lat    = lat;
    e.exp_gap    = gap;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic start_op(input logic [23:0] ang, output int acc_cyc);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_angle = ang;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    acc_cyc = cyc;
    check("accept_busy", bus.o_busy === 1'b1, $sformatf("got %b want 1", bus.o_busy));
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((sb.size() != 0 || bus.o_busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_drain"}, k < 60, $sformatf("still busy/pending after %0d cycles", k));
  endtask

  task automatic run_one(input string nm, input logic [23:0] ang, input logic [23:0] s,
                         input int tol, input bit chk, input bit rerr);
    int acc;
    start_op(ang, acc);
    push_exp(nm, s, tol, chk, rerr, acc, LAT, 0);
    wait_drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc_c, d0, cnt, k;
    bus.i_start = 1'b0;
    bus.i_angle = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.o_busy === 1'b0, $sformatf("got %b want 0", bus.o_busy));
    check("rst_done", bus.o_done === 1'b0, $sformatf("got %b want 0", bus.o_done));
    check("rst_sin", bus.o_sin === 24'h000000, $sformatf("got %06h want 000000", bus.o_sin));
    check("rst_rerr", bus.o_range_err === 1'b0, $sformatf("got %b want 0", bus.o_range_err));

    // Reset landing in the s4 cycle aborts the run without a done pulse.
    d0 = done_total;
    start_op(24'h001922, acc_c);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_total == d0, $sformatf("got %0d pulses want 0", done_total - d0));
    check("midrst_sin", bus.o_sin === 24'h000000, $sformatf("got %06h want 000000", bus.o_sin));
    check("midrst_busy", bus.o_busy === 1'b0, $sformatf("got %b want 0", bus.o_busy));

    run_one("zero",    24'h000000, 24'h000000, 0, 1'b1, 1'b0);
    run_one("pi6_pos", 24'h000861, 24'h000800, 6, 1'b1, 1'b0);
    run_one("pi6_neg", 24'h800861, 24'h800800, 6, 1'b1, 1'b0);
    run_one("pi2",     24'h001922, 24'h001000, 6, 1'b1, 1'b0);
`ifdef SINE_SEQ_QUADRANT_EN
    run_one("pi",      24'h003244, 24'h000000, 8, 1'b1, 1'b0);
`else
    run_one("pi",      24'h003244, 24'h000000, 0, 1'b0, 1'b1);
`endif

    // Start held high: three results spaced exactly GAP cycles apart.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_angle = 24'h000861;
    @(posedge clk);
    #1;
    acc_c = cyc;
    push_exp("b2b_0", 24'h000800, 6, 1'b1, 1'b0, acc_c, LAT, 0);
    push_exp("b2b_1", 24'h000800, 6, 1'b1, 1'b0, 0, 0, GAP);
    push_exp("b2b_2", 24'h000800, 6, 1'b1, 1'b0, 0, 0, GAP);
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 80) begin
      @(negedge clk);
      k++;
      if (bus.o_done) cnt++;
    end
    bus.i_start = 1'b0;
    check("b2b_count", cnt == 3, $sformatf("got %0d results want 3", cnt));
    wait_drain("b2b");

    // Start pulses and angle changes during RUN and DONE must not disturb the run.
    d0 = done_total;
    start_op(24'h000861, acc_c);
    push_exp("ignore", 24'h000800, 6, 1'b1, 1'b0, acc_c, LAT, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_angle = 24'h001922;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_angle = 24'h803244;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_drain("ignore");
    repeat (15) @(negedge clk);
    check("ignore_single_done", done_total == d0 + 1,
          $sformatf("got %0d pulses want 1", done_total - d0));
    check("ignore_idle", bus.o_busy === 1'b0, $sformatf("got %b want 0", bus.o_busy));

    check("scoreboard_empty", sb.size() == 0, $sformatf("%0d results never arrived", sb.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sine_seq_ctrl.md
# sine_seq_ctrl

Sequenced sine evaluator for the rotor model: one shared sign-magnitude Q12.12 multiplier and one sign-magnitude adder, stepped by an FSM through a 7th-order odd polynomial. The multiplier and adder are instantiated internally as `qmult_SN` and `qadd_SN`. It replaces a fully parallel multiplier tree with one multiply per cycle, so a single multiplier serves the whole sine computation. Requesters use a start/done handshake and get a registered result.

## Interface
- `N`, 24: word width. Sign-magnitude, MSB is the sign.
- `Q`, 12: fraction bits. Coefficient constants are Q12, so only N=24, Q=12 is legal.
- `i_clk` input 1: clock. All state updates on the rising edge.
- `i_rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `i_start` input 1: request. Sampled only in IDLE.
- `i_angle` input N: angle in radians, sign-magnitude Q12.12. Sampled on the accepting edge.
- `o_busy` output 1: high from the accepting edge until DONE exits.
- `o_done` output 1: one-cycle pulse when `o_sin` updates.
- `o_sin` output N: sine result, sign-magnitude Q12.12. Held until the next completion.
- `o_range_err` output 1: input out of polynomial range. Registered with `o_sin`.

## Operation
- **Constants** (sign-magnitude hex):
  - K=0x000A2F (2/π)
  - C1=0x001921
  - C3=0x800A56 (negative)
  - C5=0x000146
  - C7=0x800013 (negative)
- **States:** IDLE → RUN → DONE → IDLE.
- **Start:** in IDLE with `i_start`=1, latch `i_angle` into `ang`, clear step counter `s` and accumulator `acc`, go to RUN.
- **Registers:** RUN does one multiply per cycle. Operands are chosen by `s`; the product goes to the register named for that step.
- **Step schedule:**
  - s0: y=ang·K
  - [fold step, see Configuration]
  - s1: y2=y·y
  - s2: y3=y·y2
  - s3: acc=y·C1
  - s4: acc=acc+y3·C3
  - s5: y5=y3·y2
  - s6: acc=acc+y5·C5
  - s7: y7=y5·y2
  - s8: acc=acc+y7·C7, go to DONE
- **Multiply:** magnitudes multiply as (N-1)×(N-1) bits. The result keeps bits [N-2+Q:Q] and its sign is the XOR of the operand signs. Upper bits are truncated and do not saturate.
- **Add:** sign-magnitude, as `qadd_SN`. A zero-magnitude result always has sign 0.
- **DONE** (one cycle):
  - `o_sin`←`acc`, and `o_done`=1.
  - Any negative-zero value is forced to 0x000000.
  - `i_start` is ignored in this cycle.
- **Busy:** `i_start` during RUN or DONE is dropped, not queued. `i_angle` changes after acceptance have no effect.
- **Range error:** `o_range_err` goes high when the polynomial argument magnitude exceeds 1.0 (0x001000). Without the macro the argument is |y|; with it, the folded argument.

## Timing
- **Reset values:** `o_busy`=0, `o_done`=0, `o_sin`=0x000000, `o_range_err`=0. State is IDLE and all internal registers are 0.
- **Latency:** start accepted at edge E0. The RUN steps run on edges E1..E9 (E1..E10 with the fold). `o_done` is high for the cycle after E10 (E11 with the fold), and `o_sin` is valid in that same cycle.
- **Throughput:** one result per 11 cycles (12 with the fold). The earliest re-accept is on the edge that leaves DONE, if `i_start` is high and the state is then IDLE; in practice this is the cycle after `o_done`.
- **`o_busy`:** falls on the same edge that drops `o_done`.
- **Reset mid-operation:** `i_rst_n` low at any time clears everything asynchronously. The partial result is discarded and `o_done` does not pulse. Operation resumes from IDLE on the first edge after release.

## Configuration
- **Macro:** `SINE_SEQ_QUADRANT_EN`.
- **Defined:** a fold step runs after s0 and takes one extra cycle. Let q = integer part of |y| mod 4 and f = fractional part of |y|.
  - q0: arg=f
  - q1: arg=1.0−f
  - q2: arg=−f
  - q3: arg=−(1.0−f)
  - The sign of y is XORed into the sign of arg, and y←arg.
  - `o_range_err` is then always 0; any angle is valid.
- **Undefined:** no fold step and 11-cycle throughput. The input must satisfy |angle| ≤ π/2 (0x001922). Larger values set `o_range_err`=1 with the result still computed, which is an unspecified value.

## Test plan
- **Reset:** reset asserted, then released → all outputs 0, `o_busy`=0. Reset again at step s4 of a run → no `o_done` pulse, `o_sin` stays 0x000000.
- **Zero:** `i_angle`=0x000000 → `o_sin`=0x000000 exactly, sign 0, `o_done` pulse 10 cycles after the start edge (11 with the macro).
- **π/6:** `i_angle`=0x000861 → `o_sin`=0x000800±6 LSB. `i_angle`=0x800861 → `o_sin`=0x800800±6 LSB.
- **π/2:** `i_angle`=0x001922 → `o_sin`=0x001000±6 LSB, `o_range_err`=0.
- **π:** `i_angle`=0x003244. With the macro → |`o_sin`| ≤ 8 LSB, `o_range_err`=0. Without it → `o_range_err`=1.
- **Handshake:** `i_start` held high continuously → results spaced exactly 11 (12 with the macro) cycles apart. `i_start` pulses while `o_busy`=1 are ignored, and `i_angle` changes mid-run do not alter the result.
